id_ex_stage: RTL
================

// Module: id_ex_stage
// PURPOSE
//   ID/EX pipeline register and operand-forwarding front end of the execute stage.
//   Captures decoded operands each cycle and resolves RAW hazards from MEM and WB.
//   Drives the ALU operand A, operand B and 4-bit op, plus store data and
//   destination info forwarded to EX/MEM. Supports stall (hold) and flush (bubble).
// PARAMETERS
//   XLEN     32  datapath width
//   RA_W     5   register-address width
// PORTS
//   clk           in   1     clock, rising edge
//   rst_n         in   1     reset, synchronous, active-low
//   stall         in   1     hold stage contents (from hazard unit)
//   flush         in   1     replace contents with bubble next edge
//   id_valid      in   1     ID slot holds a real instruction
//   id_pc         in   XLEN  instruction PC
//   id_rs1/id_rs2 in   RA_W  source register indices
//   id_rs1_data   in   XLEN  regfile read data, rs1
//   id_rs2_data   in   XLEN  regfile read data, rs2
//   id_imm        in   XLEN  sign-extended immediate
//   id_rd         in   RA_W  destination register
//   id_reg_write  in   1     instruction writes rd
//   id_alu_op     in   4     ALU op code (ADD=0000, SUB=1000, ...)
//   id_src_a_pc   in   1     1: operand A = PC, 0: rs1
//   id_src_b_imm  in   1     1: operand B = imm, 0: rs2
//   mem_fwd_en    in   1     MEM-stage instruction writes mem_rd
//   mem_rd        in   RA_W  MEM-stage destination
//   mem_result    in   XLEN  MEM-stage result
//   wb_fwd_en     in   1     WB-stage instruction writes wb_rd
//   wb_rd         in   RA_W  WB-stage destination
//   wb_result     in   XLEN  WB-stage result
//   ex_valid      out  1     EX slot holds a real instruction
//   ex_a / ex_b   out  XLEN  ALU operands
//   ex_alu_op     out  4     ALU op code, passed through unchanged
//   ex_store_data out  XLEN  forwarded rs2 value (independent of src_b select)
//   ex_rd         out  RA_W  destination register
//   ex_reg_write  out  1     gated by ex_valid
//   ex_pc         out  XLEN  instruction PC
// BEHAVIOUR
//   - Reset (rst_n=0 at edge): all state 0; ex_valid=0, ex_alu_op=4'b0000, ex_reg_write=0.
//   - Capture: rising edge with rst_n=1, flush=0, stall=0 loads all id_* fields; latency 1.
//   - Priority per edge: reset > flush > stall > capture.
//   - Flush (including flush with stall): bubble = valid 0, reg_write 0, alu_op 0000, rd 0.
//   - Stall: all fields hold, except a held rsX_data is overwritten with wb_result when
//     wb_fwd_en && wb_rd==rsX && rsX!=0. This preserves a regfile write that lands during the stall.
//   - Forwarding (combinational, on registered rs1/rs2): MEM match > WB match > stored
//     data. Match = fwd_en && rd==rsX && rsX!=0. Register x0 always reads as stored data.
//   - ex_a = src_a_pc ? ex_pc : fwd_rs1; ex_b = src_b_imm ? imm : fwd_rs2.
//   - ex_store_data = fwd_rs2 always. ex_reg_write = reg_write & valid.
//   - Forwarding applies while ex_valid=0 but is harmless because reg_write is gated.
//   - No arithmetic here; widths pass through, no extension.
// TESTING
//   - Reset: rst_n=0 one edge -> ex_valid=0, ex_a=ex_b=0, ex_alu_op=0000.
//   - Capture: rs1_data=5, rs2_data=7, op=1000, no fwd -> next cycle ex_a=5, ex_b=7, op=1000.
//   - Fwd priority: ex_rs1=3, mem_rd=3 (0xAA), wb_rd=3 (0xBB) -> ex_a=0xAA.
//     Drop MEM -> ex_a=0xBB.
//   - x0: ex_rs1=0, mem_fwd_en=1, mem_rd=0, mem_result=0xFF -> ex_a = stored 0.
//   - Stall refresh: stall=1 for 2 cycles; WB writes x4=0x1234 while ex_rs2=4 -> after
//     release, with fwd off, ex_b=0x1234.
//   - Flush+stall same edge: stall=1, flush=1 -> next cycle ex_valid=0, ex_reg_write=0, op=0000.

Source files
------------

// File: rtl/id_ex_stage.sv
// rtl/id_ex_stage.sv - ID/EX pipeline register with MEM/WB operand forwarding
//
// Captures the decoded instruction each edge (stall holds, flush inserts a
// bubble) and resolves RAW hazards on the registered source indices.
//
// Ports:
//   clk, rst_n                      clock, synchronous active-low reset
//   stall, flush                    hold / bubble controls from hazard unit
//   id_*                            decoded instruction fields from ID
//   mem_fwd_en, mem_rd, mem_result  MEM-stage writeback candidate
//   wb_fwd_en, wb_rd, wb_result     WB-stage writeback candidate
//   ex_valid, ex_a, ex_b, ex_alu_op ALU operands and control
//   ex_store_data                   forwarded rs2 for stores
//   ex_rd, ex_reg_write, ex_pc      destination info and PC toward EX/MEM
module id_ex_stage #(
    parameter int XLEN = 32,
    parameter int RA_W = 5
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic            stall,
    input  logic            flush,
    input  logic            id_valid,
    input  logic [XLEN-1:0] id_pc,
    input  logic [RA_W-1:0] id_rs1,
    input  logic [RA_W-1:0] id_rs2,
    input  logic [XLEN-1:0] id_rs1_data,
    input  logic [XLEN-1:0] id_rs2_data,
    input  logic [XLEN-1:0] id_imm,
    input  logic [RA_W-1:0] id_rd,
    input  logic            id_reg_write,
    input  logic [3:0]      id_alu_op,
    input  logic            id_src_a_pc,
    input  logic            id_src_b_imm,
    input  logic            mem_fwd_en,
    input  logic [RA_W-1:0] mem_rd,
    input  logic [XLEN-1:0] mem_result,
    input  logic            wb_fwd_en,
    input  logic [RA_W-1:0] wb_rd,
    input  logic [XLEN-1:0] wb_result,
    output logic            ex_valid,
    output logic [XLEN-1:0] ex_a,
    output logic [XLEN-1:0] ex_b,
    output logic [3:0]      ex_alu_op,
    output logic [XLEN-1:0] ex_store_data,
    output logic [RA_W-1:0] ex_rd,
    output logic            ex_reg_write,
    output logic [XLEN-1:0] ex_pc
);

    logic            valid_q;
    logic [XLEN-1:0] pc_q;
    logic [RA_W-1:0] rs1_q;
    logic [RA_W-1:0] rs2_q;
    logic [XLEN-1:0] rs1_data_q;
    logic [XLEN-1:0] rs2_data_q;
    logic [XLEN-1:0] imm_q;
    logic [RA_W-1:0] rd_q;
    logic            reg_write_q;
    logic [3:0]      alu_op_q;
    logic            src_a_pc_q;
    logic            src_b_imm_q;

    // A regfile write landing while we are stalled would otherwise be lost:
    // the held read data predates it and WB will have moved on by release.
    logic wb_hit_rs1;
    logic wb_hit_rs2;
    assign wb_hit_rs1 = wb_fwd_en && (wb_rd == rs1_q) && (rs1_q != '0);
    assign wb_hit_rs2 = wb_fwd_en && (wb_rd == rs2_q) && (rs2_q != '0);

    always_ff @(posedge clk) begin
        if (!rst_n || flush) begin
            valid_q     <= 1'b0;
            pc_q        <= '0;
            rs1_q       <= '0;
            rs2_q       <= '0;
            rs1_data_q  <= '0;
            rs2_data_q  <= '0;
            imm_q       <= '0;
            rd_q        <= '0;
            reg_write_q <= 1'b0;
            alu_op_q    <= 4'b0000;
            src_a_pc_q  <= 1'b0;
            src_b_imm_q <= 1'b0;
        end else if (stall) begin
            if (wb_hit_rs1) rs1_data_q <= wb_result;
            if (wb_hit_rs2) rs2_data_q <= wb_result;
        end else begin
            valid_q     <= id_valid;
            pc_q        <= id_pc;
            rs1_q       <= id_rs1;
            rs2_q       <= id_rs2;
            rs1_data_q  <= id_rs1_data;
            rs2_data_q  <= id_rs2_data;
            imm_q       <= id_imm;
            rd_q        <= id_rd;
            reg_write_q <= id_reg_write;
            alu_op_q    <= id_alu_op;
            src_a_pc_q  <= id_src_a_pc;
            src_b_imm_q <= id_src_b_imm;
        end
    end

    // MEM holds the younger result, so it wins over WB; x0 never forwards.
    logic [XLEN-1:0] fwd_rs1;
    logic [XLEN-1:0] fwd_rs2;

    always_comb begin
        fwd_rs1 = rs1_data_q;
        if (mem_fwd_en && (mem_rd == rs1_q) && (rs1_q != '0))
            fwd_rs1 = mem_result;
        else if (wb_hit_rs1)
            fwd_rs1 = wb_result;
    end

    always_comb begin
        fwd_rs2 = rs2_data_q;
        if (mem_fwd_en && (mem_rd == rs2_q) && (rs2_q != '0))
            fwd_rs2 = mem_result;
        else if (wb_hit_rs2)
            fwd_rs2 = wb_result;
    end

    assign ex_valid      = valid_q;
    assign ex_pc         = pc_q;
    assign ex_a          = src_a_pc_q ? pc_q : fwd_rs1;
    assign ex_b          = src_b_imm_q ? imm_q : fwd_rs2;
    assign ex_alu_op     = alu_op_q;
    assign ex_store_data = fwd_rs2;
    assign ex_rd         = rd_q;
    assign ex_reg_write  = reg_write_q & valid_q;

endmodule
